// File: rtl/amba_axi4_lite_txn_monitor_if.sv
// AXI4-Lite signal bundle observed by the transaction monitor.
// master/slave modports describe the two bus agents; monitor sees every
// signal as an input.
interface amba_axi4_lite_txn_monitor_if #(
    parameter int ADDRESS_WIDTH = 28,
    parameter int DATA_WIDTH    = 32
) ();
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [ADDRESS_WIDTH-1:0] AWADDR;
    logic [2:0]               AWPROT;
    logic                     AWVALID;
    logic                     AWREADY;

    logic [DATA_WIDTH-1:0]    WDATA;
    logic [STRB_WIDTH-1:0]    WSTRB;
    logic                     WVALID;
    logic                     WREADY;

    logic [1:0]               BRESP;
    logic                     BVALID;
    logic                     BREADY;

    logic [ADDRESS_WIDTH-1:0] ARADDR;
    logic [2:0]               ARPROT;
    logic                     ARVALID;
    logic                     ARREADY;

    logic [DATA_WIDTH-1:0]    RDATA;
    logic [1:0]               RRESP;
    logic                     RVALID;
    logic                     RREADY;

    modport master (
        output AWADDR, AWPROT, AWVALID, input  AWREADY,
        output WDATA, WSTRB, WVALID,    input  WREADY,
        input  BRESP, BVALID,           output BREADY,
        output ARADDR, ARPROT, ARVALID, input  ARREADY,
        input  RDATA, RRESP, RVALID,    output RREADY
    );

    modport slave (
        input  AWADDR, AWPROT, AWVALID, output AWREADY,
        input  WDATA, WSTRB, WVALID,    output WREADY,
        output BRESP, BVALID,           input  BREADY,
        input  ARADDR, ARPROT, ARVALID, output ARREADY,
        output RDATA, RRESP, RVALID,    input  RREADY
    );

    modport monitor (
        input AWADDR, AWPROT, AWVALID, AWREADY,
        input WDATA, WSTRB, WVALID, WREADY,
        input BRESP, BVALID, BREADY,
        input ARADDR, ARPROT, ARVALID, ARREADY,
        input RDATA, RRESP, RVALID, RREADY
    );
endinterface

// File: rtl/amba_axi4_lite_txn_monitor.sv
// AXI4-Lite passive transaction monitor: tracks outstanding write/read
// transactions and early W beats, checks VALID/READY protocol rules per
// channel, and counts error responses.
// err bits: 0 AW overflow, 1 AR overflow, 2 B underflow, 3 R underflow,
//           4 payload changed while stalled, 5 VALID dropped while stalled,
//           6 wait timeout, 7 W overflow.
module amba_axi4_lite_txn_monitor #(
    parameter int  ADDRESS_WIDTH   = 28,
    parameter int  DATA_WIDTH      = 32,
    parameter int  MAX_OUTSTANDING = 4,
    parameter int  MAXWAIT         = 16,
    localparam int STRB_WIDTH      = DATA_WIDTH / 8,
    localparam int OW              = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                          ACLK,
    input  logic                          ARESETn,
    amba_axi4_lite_txn_monitor_if.monitor bus,
    input  logic                          clear_err,
    output logic [OW-1:0]                 wr_outstanding,
    output logic [OW-1:0]                 rd_outstanding,
    output logic [OW-1:0]                 w_pending,
    output logic [7:0]                    err_sticky,
    output logic [7:0]                    err_pulse,
    output logic [15:0]                   wr_resp_err_cnt,
    output logic [15:0]                   rd_resp_err_cnt
);
    // Channel index order: 0 AW, 1 W, 2 B, 3 AR, 4 R
    localparam int NCH = 5;
    localparam int AWP = ADDRESS_WIDTH + 3;
    localparam int WP  = DATA_WIDTH + STRB_WIDTH;
    localparam int RP  = DATA_WIDTH + 2;
    localparam int PW0 = (AWP > WP) ? AWP : WP;
    localparam int PW  = (PW0 > RP) ? PW0 : RP;
    localparam int WW  = (MAXWAIT > 0) ? $clog2(MAXWAIT + 1) : 1;

    localparam logic [OW-1:0] MAXO = OW'(MAX_OUTSTANDING);
    localparam logic [WW-1:0] WLIM = WW'(MAXWAIT);

    logic           aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic [NCH-1:0] vld, rdy, stall;
    logic [PW-1:0]  pay    [NCH];
    logic [NCH-1:0] stall_q;
    logic [PW-1:0]  pay_q  [NCH];
    logic [WW-1:0]  wcnt_q [NCH];
    logic [WW-1:0]  wcnt_d [NCH];
    logic           armed;
    logic [7:0]     det;
    logic [OW-1:0]  wr_d, wp_d, rd_d;
    logic [15:0]    wre_d, rre_d;

    // Gather per-channel VALID/READY and payload into uniform vectors
    always_comb begin
        vld   = {bus.RVALID, bus.ARVALID, bus.BVALID, bus.WVALID, bus.AWVALID};
        rdy   = {bus.RREADY, bus.ARREADY, bus.BREADY, bus.WREADY, bus.AWREADY};
        stall = vld & ~rdy;
        aw_hs = vld[0] & rdy[0];
        w_hs  = vld[1] & rdy[1];
        b_hs  = vld[2] & rdy[2];
        ar_hs = vld[3] & rdy[3];
        r_hs  = vld[4] & rdy[4];
        pay[0] = PW'({bus.AWADDR, bus.AWPROT});
        pay[1] = PW'({bus.WDATA, bus.WSTRB});
        pay[2] = PW'(bus.BRESP);
        pay[3] = PW'({bus.ARADDR, bus.ARPROT});
        pay[4] = PW'({bus.RDATA, bus.RRESP});
    end

    // Next-state counters and error detection for the coming edge
    always_comb begin
        det   = '0;
        wr_d  = wr_outstanding;
        wp_d  = w_pending;
        rd_d  = rd_outstanding;

        if (aw_hs && !b_hs) begin
            if (wr_outstanding == MAXO) det[0] = 1'b1;
            else                        wr_d = wr_outstanding + OW'(1);
        end else if (b_hs && !aw_hs && wr_outstanding != '0) begin
            wr_d = wr_outstanding - OW'(1);
        end

        if (w_hs && !b_hs) begin
            if (w_pending == MAXO) det[7] = 1'b1;
            else                   wp_d = w_pending + OW'(1);
        end else if (b_hs && !w_hs && w_pending != '0) begin
            wp_d = w_pending - OW'(1);
        end

        if (b_hs && (wr_outstanding == '0 || w_pending == '0)) det[2] = 1'b1;

        if (ar_hs && !r_hs) begin
            if (rd_outstanding == MAXO) det[1] = 1'b1;
            else                        rd_d = rd_outstanding + OW'(1);
        end else if (r_hs && !ar_hs) begin
            if (rd_outstanding == '0) det[3] = 1'b1;
            else                      rd_d = rd_outstanding - OW'(1);
        end

        for (int unsigned i = 0; i < NCH; i++) begin
            if (stall_q[i] && pay[i] != pay_q[i]) det[4] = 1'b1;
            if (stall_q[i] && !vld[i])            det[5] = 1'b1;
            // Counter saturates at the limit so the timeout fires once per stall
            wcnt_d[i] = '0;
            if (stall[i]) begin
                wcnt_d[i] = (wcnt_q[i] == WLIM) ? wcnt_q[i] : wcnt_q[i] + WW'(1);
                if ((MAXWAIT > 0) && wcnt_q[i] != WLIM && (wcnt_q[i] + WW'(1)) == WLIM)
                    det[6] = 1'b1;
            end
        end

        if (!armed) det = '0;

        wre_d = clear_err ? '0 : wr_resp_err_cnt;
        if (b_hs && bus.BRESP != 2'b00 && wre_d != 16'hFFFF) wre_d = wre_d + 16'd1;
        rre_d = clear_err ? '0 : rd_resp_err_cnt;
        if (r_hs && bus.RRESP != 2'b00 && rre_d != 16'hFFFF) rre_d = rre_d + 16'd1;
    end

    // Register counters, channel history and error outputs
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            armed           <= 1'b0;
            wr_outstanding  <= '0;
            rd_outstanding  <= '0;
            w_pending       <= '0;
            err_sticky      <= '0;
            err_pulse       <= '0;
            wr_resp_err_cnt <= '0;
            rd_resp_err_cnt <= '0;
            stall_q         <= '0;
            for (int unsigned i = 0; i < NCH; i++) begin
                pay_q[i]  <= '0;
                wcnt_q[i] <= '0;
            end
        end else begin
            armed           <= 1'b1;
            wr_outstanding  <= wr_d;
            rd_outstanding  <= rd_d;
            w_pending       <= wp_d;
            err_pulse       <= det;
            err_sticky      <= (clear_err ? '0 : err_sticky) | det;
            wr_resp_err_cnt <= wre_d;
            rd_resp_err_cnt <= rre_d;
            stall_q         <= stall;
            for (int unsigned i = 0; i < NCH; i++) begin
                pay_q[i]  <= pay[i];
                wcnt_q[i] <= wcnt_d[i];
            end
        end
    end
endmodule

// File: tb/tb_amba_axi4_lite_txn_monitor.sv
// Bench for amba_axi4_lite_txn_monitor: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_amba_axi4_lite_txn_monitor;
    localparam int AWW  = 28;
    localparam int DW   = 32;
    localparam int MAXO = 4;
    localparam int MW   = 16;

    logic        ACLK;
    logic        ARESETn;
    logic        clear_err;
    logic [2:0]  wr_outstanding, rd_outstanding, w_pending;
    logic [7:0]  err_sticky, err_pulse;
    logic [15:0] wr_resp_err_cnt, rd_resp_err_cnt;

    int checks = 0;
    int errors = 0;

    amba_axi4_lite_txn_monitor_if #(.ADDRESS_WIDTH(AWW), .DATA_WIDTH(DW)) bus ();

    amba_axi4_lite_txn_monitor #(
        .ADDRESS_WIDTH(AWW), .DATA_WIDTH(DW),
        .MAX_OUTSTANDING(MAXO), .MAXWAIT(MW)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .bus(bus), .clear_err(clear_err),
        .wr_outstanding(wr_outstanding), .rd_outstanding(rd_outstanding),
        .w_pending(w_pending), .err_sticky(err_sticky), .err_pulse(err_pulse),
        .wr_resp_err_cnt(wr_resp_err_cnt), .rd_resp_err_cnt(rd_resp_err_cnt)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_wr, m_wp, m_rd, m_wresp, m_rresp, since_rst;
    logic [7:0]  m_sticky, m_pulse;
    bit          h_stall [5];
    logic [63:0] h_pay   [5];
    int          h_wait  [5];

    task automatic model_reset();
        m_wr = 0; m_wp = 0; m_rd = 0; m_wresp = 0; m_rresp = 0;
        m_sticky = '0; m_pulse = '0; since_rst = 0;
        for (int i = 0; i < 5; i++) begin
            h_stall[i] = 0; h_pay[i] = '0; h_wait[i] = 0;
        end
    endtask

    task automatic model_step();
        bit          v [5];
        bit          r [5];
        logic [63:0] p [5];
        logic [7:0]  e;
        int          nwr, nwp, nrd;
        e = '0;
        v[0] = bus.AWVALID; r[0] = bus.AWREADY; p[0] = 64'({bus.AWADDR, bus.AWPROT});
        v[1] = bus.WVALID;  r[1] = bus.WREADY;  p[1] = 64'({bus.WDATA, bus.WSTRB});
        v[2] = bus.BVALID;  r[2] = bus.BREADY;  p[2] = 64'(bus.BRESP);
        v[3] = bus.ARVALID; r[3] = bus.ARREADY; p[3] = 64'({bus.ARADDR, bus.ARPROT});
        v[4] = bus.RVALID;  r[4] = bus.RREADY;  p[4] = 64'({bus.RDATA, bus.RRESP});

        if (v[2] && r[2] && (m_wr == 0 || m_wp == 0)) e[2] = 1;
        if (v[4] && r[4] && !(v[3] && r[3]) && m_rd == 0) e[3] = 1;

        nwr = m_wr + int'(v[0] && r[0]) - int'(v[2] && r[2]);
        if (nwr > MAXO) begin e[0] = 1; nwr = MAXO; end
        if (nwr < 0) nwr = 0;
        nwp = m_wp + int'(v[1] && r[1]) - int'(v[2] && r[2]);
        if (nwp > MAXO) begin e[7] = 1; nwp = MAXO; end
        if (nwp < 0) nwp = 0;
        nrd = m_rd + int'(v[3] && r[3]) - int'(v[4] && r[4]);
        if (nrd > MAXO) begin e[1] = 1; nrd = MAXO; end
        if (nrd < 0) nrd = 0;

        for (int i = 0; i < 5; i++) begin
            if (h_stall[i] && p[i] != h_pay[i]) e[4] = 1;
            if (h_stall[i] && !v[i]) e[5] = 1;
            h_wait[i] = (v[i] && !r[i]) ? h_wait[i] + 1 : 0;
            if (MW > 0 && h_wait[i] == MW) e[6] = 1;
            h_stall[i] = v[i] && !r[i];
            h_pay[i]   = p[i];
        end

        if (since_rst == 0) e = '0;

        if (clear_err) begin m_wresp = 0; m_rresp = 0; end
        if (v[2] && r[2] && bus.BRESP != 2'b00) m_wresp = (m_wresp + 1 > 65535) ? 65535 : m_wresp + 1;
        if (v[4] && r[4] && bus.RRESP != 2'b00) m_rresp = (m_rresp + 1 > 65535) ? 65535 : m_rresp + 1;

        m_sticky = (clear_err ? 8'h00 : m_sticky) | e;
        m_pulse  = e;
        m_wr = nwr; m_wp = nwp; m_rd = nrd;
        since_rst++;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge ACLK or negedge ARESETn);
            if (!ARESETn) model_reset();
            else          model_step();
        end
    end

    // Compare all outputs against the model after every active edge
    initial begin
        forever begin
            @(posedge ACLK);
            #1;
            if (ARESETn) begin
                check("cyc_wr_outstanding", wr_outstanding, m_wr);
                check("cyc_w_pending", w_pending, m_wp);
                check("cyc_rd_outstanding", rd_outstanding, m_rd);
                check("cyc_err_pulse", err_pulse, m_pulse);
                check("cyc_err_sticky", err_sticky, m_sticky);
                check("cyc_wr_resp_err_cnt", wr_resp_err_cnt, m_wresp);
                check("cyc_rd_resp_err_cnt", rd_resp_err_cnt, m_rresp);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge ACLK);
    endtask

    task automatic idle();
        bus.AWVALID = 0; bus.AWREADY = 0; bus.WVALID = 0; bus.WREADY = 0;
        bus.BVALID = 0;  bus.BREADY = 0;  bus.ARVALID = 0; bus.ARREADY = 0;
        bus.RVALID = 0;  bus.RREADY = 0;  clear_err = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr"}, wr_outstanding, 0);
        check({tag, "_rd"}, rd_outstanding, 0);
        check({tag, "_wp"}, w_pending, 0);
        check({tag, "_sticky"}, err_sticky, 0);
        check({tag, "_pulse"}, err_pulse, 0);
        check({tag, "_wresp"}, wr_resp_err_cnt, 0);
        check({tag, "_rresp"}, rd_resp_err_cnt, 0);
    endtask

    task automatic do_clear();
        clear_err = 1; tick(); clear_err = 0;
    endtask

    task automatic drive_random(input bit chaotic, input int rpct);
        bit [4:0] cv, cr, st;
        cv = {bus.RVALID, bus.ARVALID, bus.BVALID, bus.WVALID, bus.AWVALID};
        cr = {bus.RREADY, bus.ARREADY, bus.BREADY, bus.WREADY, bus.AWREADY};
        st = cv & ~cr;
        for (int i = 0; i < 5; i++) begin
            bit chg;
            if (st[i] && !chaotic) cv[i] = 1;
            else                   cv[i] = ($urandom_range(0, 99) < 50);
            cr[i] = ($urandom_range(0, 99) < rpct);
            chg = (!st[i] || chaotic) && ($urandom_range(0, 2) == 0);
            if (chg) begin
                case (i)
                    0: begin bus.AWADDR = AWW'($urandom); bus.AWPROT = 3'($urandom); end
                    1: begin bus.WDATA = $urandom; bus.WSTRB = 4'($urandom); end
                    2: bus.BRESP = 2'($urandom);
                    3: begin bus.ARADDR = AWW'($urandom); bus.ARPROT = 3'($urandom); end
                    default: begin bus.RDATA = $urandom; bus.RRESP = 2'($urandom); end
                endcase
            end
        end
        {bus.RVALID, bus.ARVALID, bus.BVALID, bus.WVALID, bus.AWVALID} = cv;
        {bus.RREADY, bus.ARREADY, bus.BREADY, bus.WREADY, bus.AWREADY} = cr;
        clear_err = ($urandom_range(0, 49) == 0);
    endtask

    initial begin
        int n6, at6;
        ARESETn = 1; idle();
        bus.AWADDR = '0; bus.AWPROT = '0; bus.WDATA = '0; bus.WSTRB = '0;
        bus.BRESP = '0; bus.ARADDR = '0; bus.ARPROT = '0; bus.RDATA = '0; bus.RRESP = '0;
        #1 ARESETn = 0;
        #1 check_all_zero("reset");
        tick(); tick(); ARESETn = 1; tick(); tick();

        // Three writes, then three responses with one SLVERR
        for (int i = 0; i < 3; i++) begin
            bus.AWVALID = 1; bus.AWREADY = 1; bus.WVALID = 1; bus.WREADY = 1;
            bus.AWADDR = AWW'(i * 4);
            tick();
            check("wr_up", wr_outstanding, i + 1);
        end
        idle();
        check("wp_after_w", w_pending, 3);
        for (int i = 0; i < 3; i++) begin
            bus.BVALID = 1; bus.BREADY = 1; bus.BRESP = (i == 1) ? 2'b10 : 2'b00;
            tick();
            check("wr_down", wr_outstanding, 2 - i);
        end
        idle(); bus.BRESP = 2'b00;
        check("wr_resp_cnt", wr_resp_err_cnt, 1);
        check("wr_sticky_clean", err_sticky, 0);
        check("wp_drained", w_pending, 0);

        // Five reads with no response: overflow on the fifth
        bus.ARVALID = 1; bus.ARREADY = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 3) check("ar_no_pulse_yet", err_pulse, 0);
        end
        check("rd_saturated", rd_outstanding, 4);
        check("model_rd_saturated", m_rd, 4);
        check("ar_ovf_pulse", err_pulse, 8'h02);
        idle(); tick();
        check("ar_ovf_pulse_gone", err_pulse, 0);
        check("ar_ovf_sticky", err_sticky, 8'h02);
        do_clear();
        check("clear_sticky", err_sticky, 0);
        bus.RVALID = 1; bus.RREADY = 1;
        repeat (4) tick();
        idle();
        check("rd_drained", rd_outstanding, 0);

        // Lone R underflow, then simultaneous AR+R at count 2
        bus.RVALID = 1; bus.RREADY = 1; tick(); idle();
        check("r_underflow_pulse", err_pulse, 8'h08);
        check("r_underflow_rd", rd_outstanding, 0);
        tick(); do_clear();
        bus.ARVALID = 1; bus.ARREADY = 1; tick(); tick();
        check("rd_two", rd_outstanding, 2);
        bus.RVALID = 1; bus.RREADY = 1; tick();
        check("ar_r_same_rd", rd_outstanding, 2);
        check("ar_r_same_pulse", err_pulse, 0);
        bus.ARVALID = 0; bus.ARREADY = 0; tick(); tick(); idle();
        check("rd_back_zero", rd_outstanding, 0);
        tick();
        check("ar_r_sticky_clean", err_sticky, 0);

        // AW payload change while stalled, then VALID dropped while stalled
        bus.AWADDR = AWW'(32'h100); bus.AWPROT = 3'd0; bus.AWVALID = 1; bus.AWREADY = 0;
        tick();
        check("aw_stall_first", err_pulse, 0);
        bus.AWADDR = AWW'(32'h104); tick();
        check("aw_addr_change", err_pulse, 8'h10);
        bus.AWVALID = 0; tick();
        check("aw_valid_drop", err_pulse, 8'h20);
        check("aw_stab_sticky", err_sticky, 8'h30);
        tick(); do_clear();

        // AR stalled 20 cycles: one timeout pulse after the 16th wait cycle
        bus.ARADDR = AWW'(32'h40); bus.ARVALID = 1; bus.ARREADY = 0;
        n6 = 0; at6 = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (err_pulse[6]) begin n6++; at6 = k; end
        end
        check("timeout_count", n6, 1);
        check("timeout_cycle", at6, 16);
        bus.ARREADY = 1; tick();
        check("ar_after_stall", rd_outstanding, 1);
        idle(); bus.RVALID = 1; bus.RREADY = 1; tick(); idle();
        check("rd_after_stall_drain", rd_outstanding, 0);
        check("timeout_sticky", err_sticky, 8'h40);
        do_clear();

        // Reset with writes outstanding and a sticky error
        bus.AWVALID = 1; bus.AWREADY = 1; bus.WVALID = 1; bus.WREADY = 1;
        tick(); tick(); idle();
        check("pre_rst_wr", wr_outstanding, 2);
        check("pre_rst_wp", w_pending, 2);
        bus.RVALID = 1; bus.RREADY = 1; tick(); idle(); tick();
        check("pre_rst_sticky", err_sticky, 8'h08);
        #2 ARESETn = 0;
        #1 check_all_zero("midrst");
        tick(); tick(); ARESETn = 1; tick();
        bus.BVALID = 1; bus.BREADY = 1; tick(); idle();
        check("post_rst_b_pulse", err_pulse, 8'h04);
        check("post_rst_b_wr", wr_outstanding, 0);
        check("model_post_rst_sticky", m_sticky, 8'h04);
        tick(); do_clear(); tick();

        // Randomized traffic
        for (int blk = 0; blk < 12; blk++) begin
            bit chaotic;
            int rpct;
            chaotic = (blk % 3 == 2);
            rpct = (blk % 2 == 0) ? 55 : 10;
            if (blk == 6) begin
                idle(); #2 ARESETn = 0; tick(); tick(); ARESETn = 1;
            end
            for (int c = 0; c < 250; c++) begin
                drive_random(chaotic, rpct);
                tick();
            end
        end
        idle(); tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
